cache_refill_ctrl: RTL and testbench

- Miss-handling stage directly downstream of the cache tag lookup.
- Consumes miss, write_back, axi_raddr and axi_waddr from the tag stage, plus the victim line from the data array.
- Drives a simple request/ack AXI-bridge interface: optional dirty-victim writeback, then line refill or uncached single-word access.
- On completion, returns refill data and pulses refresh so the tag and data arrays install the new line.

---
 rtl/cache_refill_ctrl_pkg.sv | 14 +
 rtl/cache_refill_ctrl_if.sv | 26 ++
 rtl/cache_refill_ctrl_refill_line_buf.sv | 27 ++
 rtl/cache_refill_ctrl.sv | 105 ++++++++++
 tb/tb_cache_refill_ctrl.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/cache_refill_ctrl_pkg.sv
// cache_refill_ctrl_pkg: shared constants, FSM encoding and address helper for the refill controller.
package cache_refill_ctrl_pkg;
  localparam int LINE_WORDS = 8;
  localparam int ADDR_W = 32;
  localparam int OFFSET_W = 5;
  localparam logic TYPE_WORD = 1'b0;
  localparam logic TYPE_LINE = 1'b1;
  typedef enum logic [2:0] {
    IDLE, WB_REQ, WB_WAIT, RD_REQ, RD_RECV, INSTALL, UC_WR_REQ, UC_WR_WAIT
  } state_e;
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction
endpackage

// File: rtl/cache_refill_ctrl_if.sv
// cache_refill_ctrl_if: request/ack bridge interface; master = refill controller, slave = AXI bridge.
interface cache_refill_ctrl_if;
  import cache_refill_ctrl_pkg::*;
  logic                       rd_req;
  logic                       rd_type;
  logic [ADDR_W-1:0]          rd_addr;
  logic                       rd_rdy;
  logic                       ret_valid;
  logic                       ret_last;
  logic [31:0]                ret_data;
  logic                       wr_req;
  logic                       wr_type;
  logic [ADDR_W-1:0]          wr_addr;
  logic [3:0]                 wr_wstrb;
  logic [32*LINE_WORDS-1:0]   wr_data;
  logic                       wr_rdy;
  logic                       wr_done;
  modport master (
    output rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    input  rd_rdy, ret_valid, ret_last, ret_data, wr_rdy, wr_done
  );
  modport slave (
    input  rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    output rd_rdy, ret_valid, ret_last, ret_data, wr_rdy, wr_done
  );
endinterface

// File: rtl/cache_refill_ctrl_refill_line_buf.sv
// refill_line_buf: assembles read beats into a cacheline; counter clears per burst and wraps mod LINE_WORDS.
module refill_line_buf
  import cache_refill_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     we_i,
  input  logic [31:0]              data_i,
  output logic [32*LINE_WORDS-1:0] line_o
);
  localparam int CW = $clog2(LINE_WORDS);
  logic [LINE_WORDS-1:0][31:0] mem_q;
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (we_i) begin
      mem_q[cnt_q] <= data_i;
      cnt_q <= (cnt_q == CW'(LINE_WORDS - 1)) ? '0 : cnt_q + 1'b1;
    end
  end
  assign line_o = mem_q;
endmodule

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: miss handler (dirty writeback, line refill, uncached access).
// Define CACHE_REFILL_PERF_EN to add perf_miss_cnt/perf_wb_cnt/perf_stall_cnt outputs.
module cache_refill_ctrl
  import cache_refill_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     miss,
  input  logic                     write_back,
  input  logic [ADDR_W-1:0]        axi_raddr,
  input  logic [ADDR_W-1:0]        axi_waddr,
  input  logic [32*LINE_WORDS-1:0] victim_data,
  input  logic                     uc_req,
  input  logic [3:0]               uc_wen,
  input  logic [31:0]              uc_wdata,
  cache_refill_ctrl_if.master      bus,
  output logic                     refresh,
  output logic [32*LINE_WORDS-1:0] refill_line,
  output logic                     uc_done,
  output logic [31:0]              uc_rdata,
  output logic                     busy
`ifdef CACHE_REFILL_PERF_EN
  ,
  output logic [31:0]              perf_miss_cnt,
  output logic [31:0]              perf_wb_cnt,
  output logic [31:0]              perf_stall_cnt
`endif
);
  state_e state_q, state_d;
  logic line_q;
  logic [ADDR_W-1:0] raddr_q, waddr_q;
  logic [32*LINE_WORDS-1:0] wdata_q;
  logic [3:0] wstrb_q;
  logic last_beat, uc_rd_done;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       state_d = miss ? (write_back ? WB_REQ : RD_REQ) :
                            uc_req ? (|uc_wen ? UC_WR_REQ : RD_REQ) : IDLE;
      WB_REQ:     state_d = bus.wr_rdy ? WB_WAIT : WB_REQ;
      WB_WAIT:    state_d = bus.wr_done ? RD_REQ : WB_WAIT;
      RD_REQ:     state_d = bus.rd_rdy ? RD_RECV : RD_REQ;
      RD_RECV:    state_d = last_beat ? (line_q ? INSTALL : IDLE) : RD_RECV;
      INSTALL:    state_d = IDLE;
      UC_WR_REQ:  state_d = bus.wr_rdy ? UC_WR_WAIT : UC_WR_REQ;
      UC_WR_WAIT: state_d = bus.wr_done ? IDLE : UC_WR_WAIT;
      default:    state_d = IDLE;
    endcase
  end
  // Request context is captured once on leaving IDLE so later tag-stage changes cannot disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      line_q  <= 1'b0;
      raddr_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d != IDLE) begin
        line_q  <= miss;
        raddr_q <= miss ? line_align(axi_raddr) : axi_raddr;
        waddr_q <= miss ? line_align(axi_waddr) : axi_raddr;
        wdata_q <= miss ? victim_data : {{(32*LINE_WORDS-32){1'b0}}, uc_wdata};
        wstrb_q <= miss ? 4'hF : uc_wen;
      end
    end
  end
  assign last_beat    = state_q == RD_RECV && bus.ret_valid && bus.ret_last;
  assign uc_rd_done   = last_beat && !line_q;
  assign bus.rd_req   = state_q == RD_REQ;
  assign bus.rd_type  = line_q ? TYPE_LINE : TYPE_WORD;
  assign bus.rd_addr  = raddr_q;
  assign bus.wr_req   = state_q == WB_REQ || state_q == UC_WR_REQ;
  assign bus.wr_type  = line_q ? TYPE_LINE : TYPE_WORD;
  assign bus.wr_addr  = waddr_q;
  assign bus.wr_wstrb = wstrb_q;
  assign bus.wr_data  = wdata_q;
  assign refresh      = state_q == INSTALL;
  assign uc_done      = uc_rd_done || (state_q == UC_WR_WAIT && bus.wr_done);
  assign uc_rdata     = uc_rd_done ? bus.ret_data : '0;
  assign busy         = state_q != IDLE;
  refill_line_buf u_buf (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q == RD_REQ && bus.rd_rdy),
    .we_i   (state_q == RD_RECV && bus.ret_valid),
    .data_i (bus.ret_data),
    .line_o (refill_line)
  );
`ifdef CACHE_REFILL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_miss_cnt  <= '0;
      perf_wb_cnt    <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (state_q == IDLE && miss) perf_miss_cnt <= perf_miss_cnt + 1'b1;
      if (state_q == IDLE && miss && write_back) perf_wb_cnt <= perf_wb_cnt + 1'b1;
      if (busy) perf_stall_cnt <= perf_stall_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: directed self-checking bench for cache_refill_ctrl with a hand-driven bridge.
module tb_cache_refill_ctrl;
  import cache_refill_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic miss = 1'b0, write_back = 1'b0, uc_req = 1'b0;
  logic [31:0] axi_raddr = '0, axi_waddr = '0, uc_wdata = '0;
  logic [3:0] uc_wen = '0;
  logic [255:0] victim_data = '0;
  logic refresh, uc_done, busy;
  logic [255:0] refill_line;
  logic [31:0] uc_rdata;
`ifdef CACHE_REFILL_PERF_EN
  logic [31:0] perf_miss_cnt, perf_wb_cnt, perf_stall_cnt;
`endif
  cache_refill_ctrl_if bus();
  cache_refill_ctrl dut (
    .clk(clk), .rst(rst), .miss(miss), .write_back(write_back),
    .axi_raddr(axi_raddr), .axi_waddr(axi_waddr), .victim_data(victim_data),
    .uc_req(uc_req), .uc_wen(uc_wen), .uc_wdata(uc_wdata), .bus(bus.master),
    .refresh(refresh), .refill_line(refill_line), .uc_done(uc_done),
    .uc_rdata(uc_rdata), .busy(busy)
`ifdef CACHE_REFILL_PERF_EN
    , .perf_miss_cnt(perf_miss_cnt), .perf_wb_cnt(perf_wb_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );
  int n_chk = 0, n_fail = 0, n_refresh = 0, n_ucdone = 0;
  always @(posedge clk) begin
    if (refresh) n_refresh <= n_refresh + 1;
    if (uc_done) n_ucdone <= n_ucdone + 1;
  end
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Entered with the DUT in RD_REQ; runs the burst and checks the install.
  task automatic refill(input logic [31:0] seed, input int gap);
    logic [255:0] exp;
    int r0;
    exp = '0;
    r0 = n_refresh;
    check("rd_req", bus.rd_req, 1'b1);
    check("rd_type_line", bus.rd_type, 1'b1);
    bus.rd_rdy = 1'b1;
    tick();
    bus.rd_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < gap; g++) begin
        bus.ret_valid = 1'b0;
        tick();
        check("busy_gap", busy, 1'b1);
      end
      bus.ret_valid = 1'b1;
      bus.ret_data = seed * (i + 1);
      bus.ret_last = (i == 7);
      exp[i*32 +: 32] = seed * (i + 1);
      tick();
    end
    bus.ret_valid = 1'b0;
    bus.ret_last = 1'b0;
    miss = 1'b0;
    check("refresh_on", refresh, 1'b1);
    check("refill_line", refill_line, exp);
    tick();
    check("refresh_off", refresh, 1'b0);
    check("idle_after", busy, 1'b0);
    check("refresh_once", 32'(n_refresh - r0), 32'd1);
  endtask
  initial begin
    int u0;
    bus.rd_rdy = 1'b0; bus.ret_valid = 1'b0; bus.ret_last = 1'b0; bus.ret_data = '0;
    bus.wr_rdy = 1'b0; bus.wr_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_rd_req", bus.rd_req, 1'b0);
    check("rst_wr_req", bus.wr_req, 1'b0);
    check("rst_refresh", refresh, 1'b0);
    check("rst_uc_done", uc_done, 1'b0);
    check("rst_line", refill_line, 256'd0);
    // clean miss
    miss = 1'b1; axi_raddr = 32'h1000_0020;
    tick();
    axi_raddr = 32'h0;
    check("clean_rd_addr", bus.rd_addr, 32'h1000_0020);
    check("clean_no_wr", bus.wr_req, 1'b0);
    refill(32'h11, 0);
    // dirty miss
    miss = 1'b1; write_back = 1'b1;
    axi_waddr = 32'h2000_0040; axi_raddr = 32'h2000_0000; victim_data = {8{32'hA5A5_A5A5}};
    tick();
    write_back = 1'b0; victim_data = '0; axi_waddr = '0;
    check("wb_wr_req", bus.wr_req, 1'b1);
    check("wb_wr_type", bus.wr_type, 1'b1);
    check("wb_wstrb", bus.wr_wstrb, 4'hF);
    check("wb_addr", bus.wr_addr, 32'h2000_0040);
    check("wb_data", bus.wr_data, {8{32'hA5A5_A5A5}});
    check("wb_no_rd", bus.rd_req, 1'b0);
    bus.wr_rdy = 1'b1;
    tick();
    bus.wr_rdy = 1'b0;
    check("wb_wait_wr_req", bus.wr_req, 1'b0);
    tick(); tick();
    check("wb_wait_no_rd", bus.rd_req, 1'b0);
    bus.wr_done = 1'b1;
    tick();
    bus.wr_done = 1'b0;
    check("wb_rd_addr", bus.rd_addr, 32'h2000_0000);
    refill(32'h0101_0101, 0);
    // uncached read
    u0 = n_ucdone;
    uc_req = 1'b1; uc_wen = 4'h0; axi_raddr = 32'h1FAF_F004;
    tick();
    check("ucr_rd_req", bus.rd_req, 1'b1);
    check("ucr_rd_type", bus.rd_type, 1'b0);
    check("ucr_rd_addr", bus.rd_addr, 32'h1FAF_F004);
    bus.rd_rdy = 1'b1;
    tick();
    bus.rd_rdy = 1'b0; uc_req = 1'b0;
    check("ucr_no_done_early", uc_done, 1'b0);
    bus.ret_valid = 1'b1; bus.ret_last = 1'b1; bus.ret_data = 32'hDEAD_BEEF;
    #1;
    check("ucr_done", uc_done, 1'b1);
    check("ucr_rdata", uc_rdata, 32'hDEAD_BEEF);
    check("ucr_no_refresh", refresh, 1'b0);
    tick();
    bus.ret_valid = 1'b0; bus.ret_last = 1'b0;
    check("ucr_idle", busy, 1'b0);
    check("ucr_done_once", 32'(n_ucdone - u0), 32'd1);
    // uncached byte store
    u0 = n_ucdone;
    uc_req = 1'b1; uc_wen = 4'b0010; uc_wdata = 32'h0000_AB00; axi_raddr = 32'h1FAF_F008;
    tick();
    uc_req = 1'b0; uc_wen = 4'h0; uc_wdata = '0;
    check("ucw_wr_req", bus.wr_req, 1'b1);
    check("ucw_wr_type", bus.wr_type, 1'b0);
    check("ucw_wstrb", bus.wr_wstrb, 4'h2);
    check("ucw_addr", bus.wr_addr, 32'h1FAF_F008);
    check("ucw_data", bus.wr_data, 256'h0000_AB00);
    check("ucw_no_rd", bus.rd_req, 1'b0);
    bus.wr_rdy = 1'b1;
    tick();
    bus.wr_rdy = 1'b0;
    check("ucw_wait", uc_done, 1'b0);
    bus.wr_done = 1'b1;
    #1;
    check("ucw_done", uc_done, 1'b1);
    tick();
    bus.wr_done = 1'b0;
    #1;
    check("ucw_done_off", uc_done, 1'b0);
    check("ucw_idle", busy, 1'b0);
    check("ucw_done_once", 32'(n_ucdone - u0), 32'd1);
    // backpressure with gapped beats
    miss = 1'b1; axi_raddr = 32'h3000_0060;
    tick();
    axi_raddr = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_rd_req", bus.rd_req, 1'b1);
      check("stall_rd_addr", bus.rd_addr, 32'h3000_0060);
      check("stall_busy", busy, 1'b1);
    end
    refill(32'h0300_0003, 1);
    // reset during RD_RECV, then a fresh miss
    miss = 1'b1; axi_raddr = 32'h4000_0000;
    u0 = n_refresh;
    tick();
    bus.rd_rdy = 1'b1;
    tick();
    bus.rd_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.ret_valid = 1'b1; bus.ret_data = 32'hBAD0_0000 + i;
      tick();
    end
    bus.ret_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_refresh", refresh, 1'b0);
    check("rstmid_no_install", 32'(n_refresh - u0), 32'd0);
    tick();
    check("rstmid_rd_addr", bus.rd_addr, 32'h4000_0000);
    refill(32'h0000_0707, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
